// File: rtl/collector_port_arbiter_pkg.sv
// Shared definitions for the collector port arbiter: FSM encodings and the
// debug view of the arbiter's internal state.
package collector_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_WAIT_GNT = 2'd1;
    localparam logic [1:0] ARB_RELEASE  = 2'd2;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int WAIT_CNT_W = 8;

    typedef struct packed {
        logic [1:0]            state;
        logic [WAIT_CNT_W-1:0] waitcnt;
    } arb_dbg_t;

endpackage

// File: rtl/collector_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at NUM_REQ-1 back to 0.
module collector_port_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [IDW-1:0]     idx
);

    // One extra bit so ptr+k can exceed NUM_REQ-1 before being folded back.
    logic [IDW:0] cand;
    logic         hit;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        hit  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            hit = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (cand == (IDW+1)'(j) && req[j]) begin
                    hit = 1'b1;
                end
            end
            if (!any && hit) begin
                any = 1'b1;
                idx = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/collector_port_arbiter.sv
// Shares one PE collector port among NUM_REQ sources: latches the round-robin
// winner's packet, requests the collector, and hands its grant back to the winner.
module collector_port_arbiter
    import collector_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int dataWidth = 32,
    parameter int IDW       = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           ReqUpStr,
    input  logic [NUM_REQ*dataWidth-1:0] PacketIn,
    output logic [NUM_REQ-1:0]           GntUpStr,
    output logic [NUM_REQ-1:0]           UpStrFull,
    output logic                         ReqDnStr,
    output logic [dataWidth-1:0]         PacketOut,
    input  logic                         GntDnStr,
    input  logic                         DnStrFull,
    output logic [IDW-1:0]               ActiveID,
    output logic [31:0]                  PktCount,
    output logic                         TimeoutErr,
    output arb_dbg_t                     dbg
);

    logic [1:0]            state;
    logic [WAIT_CNT_W-1:0] waitcnt;
    logic [IDW-1:0]        ptr;
    logic                  pick_any;
    logic [IDW-1:0]        pick_idx;
    logic [dataWidth-1:0]  pick_pkt;
    logic [NUM_REQ-1:0]    active_onehot;
    logic [IDW-1:0]        ptr_next;

    collector_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req (ReqUpStr),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        pick_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                pick_pkt = PacketIn[i*dataWidth +: dataWidth];
            end
        end
    end

    always_comb begin
        active_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active_onehot[i] = (ActiveID == IDW'(i));
        end
    end

    // Explicit wrap so a non-power-of-two NUM_REQ never points at a missing source.
    assign ptr_next = (ActiveID == IDW'(NUM_REQ-1)) ? '0 : ActiveID + 1'b1;

    assign UpStrFull = {NUM_REQ{(state != ARB_IDLE) | DnStrFull}};

    assign dbg.state   = state;
    assign dbg.waitcnt = waitcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            ReqDnStr   <= 1'b0;
            GntUpStr   <= '0;
            PacketOut  <= '0;
            ActiveID   <= '0;
            ptr        <= '0;
            PktCount   <= '0;
            TimeoutErr <= 1'b0;
            waitcnt    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    GntUpStr <= '0;
                    if (pick_any && !DnStrFull) begin
                        PacketOut <= pick_pkt;
                        ActiveID  <= pick_idx;
                        ReqDnStr  <= 1'b1;
                        waitcnt   <= '0;
                        state     <= ARB_WAIT_GNT;
                    end
                end
                ARB_WAIT_GNT: begin
                    // A grant arriving on the timeout cycle still completes the packet.
                    if (GntDnStr) begin
                        ReqDnStr <= 1'b0;
                        GntUpStr <= active_onehot;
                        PktCount <= PktCount + 32'd1;
                        ptr      <= ptr_next;
                        state    <= ARB_RELEASE;
                    end else if (waitcnt == WAIT_CNT_W'(TIMEOUT-1)) begin
                        ReqDnStr   <= 1'b0;
                        TimeoutErr <= 1'b1;
                        state      <= ARB_IDLE;
                    end else begin
                        waitcnt <= waitcnt + 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    GntUpStr <= '0;
                    if (!GntDnStr) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    ReqDnStr <= 1'b0;
                    GntUpStr <= '0;
                    state    <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collector_port_arbiter.sv
// Directed bench for collector_port_arbiter: a 4-source instance with TIMEOUT=8
// and a 3-source instance for the non-power-of-two wrap case.
module tb_collector_port_arbiter;
    import collector_port_arbiter_pkg::*;

    localparam int NR  = 4;
    localparam int NR3 = 3;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-source instance
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] pin;
    logic [NR-1:0]    gup, upfull;
    logic             rqd, gdn, dfull, terr;
    logic [DW-1:0]    pout;
    logic [IDW-1:0]   aid;
    logic [31:0]      pcnt;
    arb_dbg_t         dbg;

    // 3-source instance
    logic [NR3-1:0]    req3;
    logic [NR3*DW-1:0] pin3;
    logic [NR3-1:0]    gup3, upfull3;
    logic              rqd3, gdn3, dfull3, terr3;
    logic [DW-1:0]     pout3;
    logic [IDW-1:0]    aid3;
    logic [31:0]       pcnt3;
    arb_dbg_t          dbg3;

    collector_port_arbiter #(.NUM_REQ(NR), .dataWidth(DW), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ReqUpStr(req), .PacketIn(pin), .GntUpStr(gup),
        .UpStrFull(upfull), .ReqDnStr(rqd), .PacketOut(pout), .GntDnStr(gdn),
        .DnStrFull(dfull), .ActiveID(aid), .PktCount(pcnt), .TimeoutErr(terr), .dbg(dbg)
    );

    collector_port_arbiter #(.NUM_REQ(NR3), .dataWidth(DW), .IDW(IDW), .TIMEOUT(TO)) dut3 (
        .clk(clk), .reset(reset), .ReqUpStr(req3), .PacketIn(pin3), .GntUpStr(gup3),
        .UpStrFull(upfull3), .ReqDnStr(rqd3), .PacketOut(pout3), .GntDnStr(gdn3),
        .DnStrFull(dfull3), .ActiveID(aid3), .PktCount(pcnt3), .TimeoutErr(terr3), .dbg(dbg3)
    );

    // Source and collector model state
    logic [NR-1:0]  req_mask, gm1, gm2;
    logic [NR3-1:0] req3_mask, g3m1, g3m2;
    logic [DW-1:0]  pkt  [NR];
    logic [DW-1:0]  pkt3 [NR3];
    logic           col_en, req_prev, req3_prev;

    // Scoreboard: {ActiveID, PacketOut} expected in collector acceptance order
    logic [IDW+DW-1:0] exp_q[$];
    logic [IDW+DW-1:0] exp3_q[$];
    logic [NR3-1:0]    g3_log[$];

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int pulse_cnt = 0;
    logic [IDW-1:0] last_acc, last_acc3;
    logic [NR-1:0]  gup_last;
    logic           last_rqd;
    logic [DW-1:0]  last_pout;

    assign req  = req_mask & ~(gm1 | gm2);
    assign req3 = req3_mask & ~(g3m1 | g3m2);

    always_comb begin
        pin = '0;
        for (int i = 0; i < NR; i++) pin[i*DW +: DW] = pkt[i];
        pin3 = '0;
        for (int i = 0; i < NR3; i++) pin3[i*DW +: DW] = pkt3[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive the source and
    // collector models for the next rising edge.
    task automatic step();
        logic [IDW+DW-1:0] e;
        logic [NR-1:0]     oh;
        @(negedge clk);
        if (gup != 0) begin
            pulse_cnt++;
            oh = 4'b0001 << last_acc;
            chk("gnt_up_target", 64'(gup), 64'(oh));
            chk("gnt_up_single", 64'(gup & gup_last), 64'd0);
        end
        if (rqd && last_rqd) chk("pkt_stable", 64'(pout), 64'(last_pout));
        last_rqd  = rqd;
        last_pout = pout;
        gup_last  = gup;
        if (gup3 != 0) g3_log.push_back(gup3);

        if (reset) begin
            gm1 = '0; gm2 = '0; g3m1 = '0; g3m2 = '0;
            gdn = 1'b0; gdn3 = 1'b0; req_prev = 1'b0; req3_prev = 1'b0;
        end else begin
            // A granted source drops its request for the two edges after the pulse.
            gm2 = gm1;   gm1 = gup;
            g3m2 = g3m1; g3m1 = gup3;
            for (int i = 0; i < NR; i++)  if (gup[i])  pkt[i]  = pkt[i]  + 32'h0001_0000;
            for (int i = 0; i < NR3; i++) if (gup3[i]) pkt3[i] = pkt3[i] + 32'h0001_0000;
            // Registered collector: grants one cycle after seeing a request.
            gdn  = col_en && req_prev && !gdn;
            req_prev = rqd;
            gdn3 = req3_prev && !gdn3;
            req3_prev = rqd3;
            if (gdn && rqd) begin
                chk("accept_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("accept_pkt", 64'({aid, pout}), 64'(e));
                end
                last_acc = aid;
                acc_cnt++;
            end
            if (gdn3 && rqd3) begin
                chk("accept3_expected", 64'(exp3_q.size() != 0), 64'd1);
                if (exp3_q.size() != 0) begin
                    e = exp3_q.pop_front();
                    chk("accept3_pkt", 64'({aid3, pout3}), 64'(e));
                end
                last_acc3 = aid3;
            end
        end
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (gup == 0 && n < budget);
        chk(tag, 64'(gup != 0), 64'd1);
    endtask

    task automatic wait_rqd(input string tag, input int budget);
        int n;
        n = 0;
        while (!rqd && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(rqd), 64'd1);
    endtask

    initial begin
        int hi;
        int n;
        reset = 1'b1;
        req_mask = '0; req3_mask = '0; gm1 = '0; gm2 = '0; g3m1 = '0; g3m2 = '0;
        col_en = 1'b1; dfull = 1'b0; dfull3 = 1'b0; gdn = 1'b0; gdn3 = 1'b0;
        req_prev = 1'b0; req3_prev = 1'b0; last_acc = '0; last_acc3 = '0;
        gup_last = '0; last_rqd = 1'b0; last_pout = '0;
        for (int i = 0; i < NR; i++)  pkt[i]  = '0;
        for (int i = 0; i < NR3; i++) pkt3[i] = '0;

        // Reset state
        step(); step();
        chk("rst_rqd", 64'(rqd), 64'd0);
        chk("rst_gup", 64'(gup), 64'd0);
        chk("rst_pout", 64'(pout), 64'd0);
        chk("rst_aid", 64'(aid), 64'd0);
        chk("rst_pcnt", 64'(pcnt), 64'd0);
        chk("rst_terr", 64'(terr), 64'd0);
        chk("rst_upfull", 64'(upfull), 64'd0);
        chk("rst_state", 64'(dbg.state), 64'(ARB_IDLE));
        reset = 1'b0;

        // Single source, nominal latency
        pkt[0] = 32'hA5A5_0003;
        exp_q.push_back({2'd0, 32'hA5A5_0003});
        req_mask = 4'b0001;
        step();
        chk("t1_rqd_e0", 64'(rqd), 64'd1);
        chk("t1_pout", 64'(pout), 64'hA5A5_0003);
        chk("t1_upfull", 64'(upfull), 64'hF);
        chk("t1_gup_e0", 64'(gup), 64'd0);
        step();
        chk("t1_gup_e1", 64'(gup), 64'd0);
        step();
        chk("t1_gup_e2", 64'(gup), 64'b0001);
        req_mask = '0;
        step();
        chk("t1_gup_e3", 64'(gup), 64'd0);
        chk("t1_pcnt", 64'(pcnt), 64'd1);
        step();

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_pcnt", 64'(pcnt), 64'd0);

        // All four requesting continuously: 0,1,2,3,0 at one packet per 4 cycles
        for (int i = 0; i < NR; i++) pkt[i] = $urandom;
        exp_q.push_back({2'd0, pkt[0]});
        exp_q.push_back({2'd1, pkt[1]});
        exp_q.push_back({2'd2, pkt[2]});
        exp_q.push_back({2'd3, pkt[3]});
        exp_q.push_back({2'd0, pkt[0] + 32'h0001_0000});
        req_mask = 4'b1111;
        repeat (20) step();
        req_mask = '0;
        chk("t2_pcnt", 64'(pcnt), 64'd5);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) step();

        // Collector full blocks new grants
        dfull = 1'b1;
        pkt[2] = $urandom;
        req_mask = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t3_rqd_held", 64'(rqd), 64'd0);
            chk("t3_upfull", 64'(upfull), 64'hF);
        end
        exp_q.push_back({2'd2, pkt[2]});
        dfull = 1'b0;
        wait_grant("t3_grant", 20);
        req_mask = '0;
        repeat (3) step();
        chk("t3_pcnt", 64'(pcnt), 64'd6);

        // Collector never grants: timeout after TIMEOUT cycles, then retry
        col_en = 1'b0;
        pkt[1] = $urandom;
        req_mask = 4'b0010;
        wait_rqd("t4_rise", 10);
        hi = 0;
        while (rqd && hi < 40) begin
            step();
            hi++;
        end
        chk("t4_len", 64'(hi), 64'(TO));
        chk("t4_terr", 64'(terr), 64'd1);
        chk("t4_no_gnt", 64'(pulse_cnt), 64'd7);
        step();
        chk("t4_retry", 64'(rqd), 64'd1);
        chk("t4_retry_id", 64'(aid), 64'd1);
        exp_q.push_back({2'd1, pkt[1]});
        col_en = 1'b1;
        wait_grant("t4_grant", 20);
        req_mask = '0;
        repeat (3) step();
        chk("t4_terr_sticky", 64'(terr), 64'd1);
        chk("t4_pcnt", 64'(pcnt), 64'd7);

        // Reset while waiting for the collector aborts the transfer
        col_en = 1'b0;
        pkt[2] = $urandom;
        req_mask = 4'b0100;
        wait_rqd("t5_rise", 10);
        step(); step();
        chk("t5_in_wait", 64'(dbg.state), 64'(ARB_WAIT_GNT));
        reset = 1'b1;
        req_mask = '0;
        step();
        chk("t5_rqd", 64'(rqd), 64'd0);
        chk("t5_gup", 64'(gup), 64'd0);
        chk("t5_pout", 64'(pout), 64'd0);
        chk("t5_aid", 64'(aid), 64'd0);
        chk("t5_pcnt", 64'(pcnt), 64'd0);
        chk("t5_terr", 64'(terr), 64'd0);
        chk("t5_state", 64'(dbg.state), 64'(ARB_IDLE));
        reset = 1'b0;
        // ptr back at 0: 4'b1001 must serve 0 before 3
        pkt[0] = $urandom;
        pkt[3] = $urandom;
        exp_q.push_back({2'd0, pkt[0]});
        exp_q.push_back({2'd3, pkt[3]});
        col_en = 1'b1;
        req_mask = 4'b1001;
        wait_grant("t5_grant_a", 20);
        wait_grant("t5_grant_b", 20);
        req_mask = '0;
        repeat (3) step();
        chk("t5_pcnt_after", 64'(pcnt), 64'd2);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // Three sources: ptr=2 with 3'b101 serves 2 then wraps to 0
        for (int i = 0; i < NR3; i++) pkt3[i] = $urandom;
        exp3_q.push_back({2'd1, pkt3[1]});
        req3_mask = 3'b010;
        n = 0;
        while (g3_log.size() < 1 && n < 20) begin
            step();
            n++;
        end
        req3_mask = '0;
        repeat (3) step();
        exp3_q.push_back({2'd2, pkt3[2]});
        exp3_q.push_back({2'd0, pkt3[0]});
        req3_mask = 3'b101;
        n = 0;
        while (g3_log.size() < 3 && n < 40) begin
            step();
            n++;
        end
        req3_mask = '0;
        repeat (3) step();
        chk("t6_grants", 64'(g3_log.size()), 64'd3);
        if (g3_log.size() == 3) begin
            chk("t6_g0", 64'(g3_log[0]), 64'b010);
            chk("t6_g1", 64'(g3_log[1]), 64'b100);
            chk("t6_g2", 64'(g3_log[2]), 64'b001);
        end
        chk("t6_pcnt", 64'(pcnt3), 64'd3);
        chk("t6_q_empty", 64'(exp3_q.size()), 64'd0);

        chk("pulses_vs_accepts", 64'(pulse_cnt), 64'(acc_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
